// File: rtl/exc_entry_pkg.sv
// exc_entry_pkg: shared definitions for the CP0 exception-entry unit.
//   - ExcT_* exception-report codes from the memory-stage detector
//   - architectural Cause.ExcCode values
//   - CP0 register addresses ({rd[4:0], sel[2:0]})
//   - Status/Cause bit-field positions and MTC0 write masks
package exc_entry_pkg;

   // Exception report codes produced by the detector.
   typedef enum logic [4:0] {
      ExcTNoExc = 5'd0,
      ExcTIntr  = 5'd1,
      ExcTAdE   = 5'd2,
      ExcTTlbr  = 5'd3,
      ExcTTlbi  = 5'd4,
      ExcTTlbm  = 5'd5,
      ExcTIbe   = 5'd6,
      ExcTDbe   = 5'd7,
      ExcTCpU   = 5'd8,
      ExcTRi    = 5'd9,
      ExcTOv    = 5'd10,
      ExcTTrap  = 5'd11,
      ExcTSysC  = 5'd12,
      ExcTBp    = 5'd13,
      ExcTEret  = 5'd14
   } exc_type_e;

   // Cause.ExcCode values.
   localparam logic [4:0] ExcCodeInt  = 5'd0;
   localparam logic [4:0] ExcCodeMod  = 5'd1;
   localparam logic [4:0] ExcCodeTlbl = 5'd2;
   localparam logic [4:0] ExcCodeTlbs = 5'd3;
   localparam logic [4:0] ExcCodeAdel = 5'd4;
   localparam logic [4:0] ExcCodeAdes = 5'd5;
   localparam logic [4:0] ExcCodeIbe  = 5'd6;
   localparam logic [4:0] ExcCodeDbe  = 5'd7;
   localparam logic [4:0] ExcCodeSys  = 5'd8;
   localparam logic [4:0] ExcCodeBp   = 5'd9;
   localparam logic [4:0] ExcCodeRi   = 5'd10;
   localparam logic [4:0] ExcCodeCpU  = 5'd11;
   localparam logic [4:0] ExcCodeOv   = 5'd12;
   localparam logic [4:0] ExcCodeTr   = 5'd13;

   // CP0 register addresses, {rd, sel}.
   localparam logic [7:0] Cp0AddrBadVAddr = {5'd8,  3'd0};
   localparam logic [7:0] Cp0AddrCount    = {5'd9,  3'd0};
   localparam logic [7:0] Cp0AddrCompare  = {5'd11, 3'd0};
   localparam logic [7:0] Cp0AddrStatus   = {5'd12, 3'd0};
   localparam logic [7:0] Cp0AddrCause    = {5'd13, 3'd0};
   localparam logic [7:0] Cp0AddrEpc      = {5'd14, 3'd0};

   // Status bit positions.
   localparam int unsigned StatusIe    = 0;
   localparam int unsigned StatusExl   = 1;
   localparam int unsigned StatusErl   = 2;
   localparam int unsigned StatusImLo  = 8;
   localparam int unsigned StatusImHi  = 15;
   localparam int unsigned StatusBev   = 22;

   // Cause bit positions.
   localparam int unsigned CauseExcLo  = 2;
   localparam int unsigned CauseExcHi  = 6;
   localparam int unsigned CauseIpLo   = 8;
   localparam int unsigned CauseIpHi   = 15;
   localparam int unsigned CauseTi     = 30;
   localparam int unsigned CauseBd     = 31;

   localparam logic [31:0] StatusWrMask  = 32'h0040_FF07;
   localparam logic [31:0] StatusRstVal  = 32'h0040_0000;

   // Map a detector report to its architectural ExcCode.
   function automatic logic [4:0] exc_code_of(input logic [4:0] exc_type, input logic save);
      logic [4:0] code;
      code = ExcCodeInt;
      case (exc_type)
         ExcTIntr:          code = ExcCodeInt;
         ExcTTlbm:          code = ExcCodeMod;
         ExcTTlbr, ExcTTlbi: code = save ? ExcCodeTlbs : ExcCodeTlbl;
         ExcTAdE:           code = save ? ExcCodeAdes : ExcCodeAdel;
         ExcTIbe:           code = ExcCodeIbe;
         ExcTDbe:           code = ExcCodeDbe;
         ExcTSysC:          code = ExcCodeSys;
         ExcTBp:            code = ExcCodeBp;
         ExcTRi:            code = ExcCodeRi;
         ExcTCpU:           code = ExcCodeCpU;
         ExcTOv:            code = ExcCodeOv;
         ExcTTrap:          code = ExcCodeTr;
         default:           code = ExcCodeInt;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/exc_entry_timer.sv
// cp0_timer: CP0 Count/Compare timer.
//   clk_i, rst_i         clock, async active-high reset
//   count_we_i           MTC0 to Count (wdata_i), restarts the half-rate toggle
//   compare_we_i         MTC0 to Compare (wdata_i), clears timer_int
//   count_o, compare_o   current register values
//   timer_int_o          registered timer interrupt
//   timer_int_next_o     next-state of timer_int (lets Cause.IP7 track TI with equal latency)
module cp0_timer (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        count_we_i,
   input  logic        compare_we_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic        timer_int_o,
   output logic        timer_int_next_o
);

   logic        toggle_q, toggle_d;
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        timer_int_q, timer_int_d;

   always_comb begin
      toggle_d    = ~toggle_q;
      count_d     = toggle_q ? count_q + 32'd1 : count_q;
      compare_d   = compare_q;
      timer_int_d = timer_int_q;

      if (count_we_i) begin
         count_d  = wdata_i;
         toggle_d = 1'b0;
      end

      // A Compare write acknowledges the interrupt even if a match happens this cycle.
      if (compare_we_i) begin
         compare_d   = wdata_i;
         timer_int_d = 1'b0;
      end else if (count_q == compare_q) begin
         timer_int_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         toggle_q    <= 1'b0;
         count_q     <= 32'd0;
         compare_q   <= 32'd0;
         timer_int_q <= 1'b0;
      end else begin
         toggle_q    <= toggle_d;
         count_q     <= count_d;
         compare_q   <= compare_d;
         timer_int_q <= timer_int_d;
      end
   end

   assign count_o          = count_q;
   assign compare_o        = compare_q;
   assign timer_int_o      = timer_int_q;
   assign timer_int_next_o = timer_int_d;

endmodule

// File: rtl/exc_entry.sv
// exc_entry: CP0 exception-entry and return unit.
//   clk_i, rst_i                    clock, async active-high reset
//   exc_flag_i, exc_type_i          exception/ERET report from the memory stage
//   exc_baddr_i, exc_save_i         faulting address, store-side fault
//   pc_i, in_dslot_i                memory-stage PC, delay-slot flag
//   ext_int_i                       level-sensitive hardware interrupts
//   cp0_we_i, cp0_addr_i, cp0_wdata_i   MTC0 port
//   cp0_rdata_o                     MFC0 data (combinational)
//   cp0_status_o, cp0_cause_o, cp0_epc_o  register values for the detector
//   flush_o, flush_pc_o             pipeline squash and redirect target
module exc_entry
   import exc_entry_pkg::*;
#(
   parameter logic [31:0] VEC_BASE     = 32'h8000_0000,
   parameter logic [31:0] VEC_BASE_BEV = 32'hBFC0_0200
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        exc_flag_i,
   input  logic [4:0]  exc_type_i,
   input  logic [31:0] exc_baddr_i,
   input  logic        exc_save_i,
   input  logic [31:0] pc_i,
   input  logic        in_dslot_i,
   input  logic [5:0]  ext_int_i,
   input  logic        cp0_we_i,
   input  logic [7:0]  cp0_addr_i,
   input  logic [31:0] cp0_wdata_i,
   output logic [31:0] cp0_rdata_o,
   output logic [31:0] cp0_status_o,
   output logic [31:0] cp0_cause_o,
   output logic [31:0] cp0_epc_o,
   output logic        flush_o,
   output logic [31:0] flush_pc_o
);

   logic [31:0] status_q, status_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] badvaddr_q, badvaddr_d;
   logic        bd_q, bd_d;
   logic [4:0]  exc_code_q, exc_code_d;
   logic [5:0]  ip_hw_q, ip_hw_d;      // Cause.IP[7:2]
   logic [1:0]  ip_sw_q, ip_sw_d;      // Cause.IP[1:0]

   logic        is_eret, is_entry, wr_en, has_baddr;
   logic [31:0] cause;
   logic [31:0] count, compare;
   logic        timer_int, timer_int_next;
   logic [31:0] vec_base, vec_off;

   assign is_eret  = exc_flag_i && (exc_type_i == ExcTEret);
   assign is_entry = exc_flag_i && (exc_type_i != ExcTEret) && (exc_type_i != ExcTNoExc);
   // Any reported exception/ERET squashes the MTC0 sitting in the same stage.
   assign wr_en    = cp0_we_i && !exc_flag_i;
   assign has_baddr = (exc_type_i == ExcTAdE) || (exc_type_i == ExcTTlbr) ||
                      (exc_type_i == ExcTTlbi) || (exc_type_i == ExcTTlbm);

   cp0_timer u_timer (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .count_we_i       (wr_en && (cp0_addr_i == Cp0AddrCount)),
      .compare_we_i     (wr_en && (cp0_addr_i == Cp0AddrCompare)),
      .wdata_i          (cp0_wdata_i),
      .count_o          (count),
      .compare_o        (compare),
      .timer_int_o      (timer_int),
      .timer_int_next_o (timer_int_next)
   );

   always_comb begin
      status_d   = status_q;
      epc_d      = epc_q;
      badvaddr_d = badvaddr_q;
      bd_d       = bd_q;
      exc_code_d = exc_code_q;
      ip_sw_d    = ip_sw_q;
      ip_hw_d    = {ext_int_i[5] | timer_int_next, ext_int_i[4:0]};

      if (wr_en) begin
         unique case (cp0_addr_i)
            Cp0AddrStatus: status_d = cp0_wdata_i & StatusWrMask;
            Cp0AddrCause:  ip_sw_d  = cp0_wdata_i[9:8];
            Cp0AddrEpc:    epc_d    = cp0_wdata_i;
            default:       ;
         endcase
      end

      if (is_entry) begin
         // Nested exceptions keep the original return point.
         if (!status_q[StatusExl]) begin
            epc_d = in_dslot_i ? pc_i - 32'd4 : pc_i;
            bd_d  = in_dslot_i;
         end
         status_d[StatusExl] = 1'b1;
         exc_code_d = exc_code_of(exc_type_i, exc_save_i);
         if (has_baddr) badvaddr_d = exc_baddr_i;
      end else if (is_eret) begin
         status_d[StatusExl] = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         status_q   <= StatusRstVal;
         epc_q      <= 32'd0;
         badvaddr_q <= 32'd0;
         bd_q       <= 1'b0;
         exc_code_q <= 5'd0;
         ip_hw_q    <= 6'd0;
         ip_sw_q    <= 2'd0;
      end else begin
         status_q   <= status_d;
         epc_q      <= epc_d;
         badvaddr_q <= badvaddr_d;
         bd_q       <= bd_d;
         exc_code_q <= exc_code_d;
         ip_hw_q    <= ip_hw_d;
         ip_sw_q    <= ip_sw_d;
      end
   end

   assign cause = {bd_q, timer_int, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exc_code_q, 2'd0};

   always_comb begin
      cp0_rdata_o = 32'd0;
      unique case (cp0_addr_i)
         Cp0AddrBadVAddr: cp0_rdata_o = badvaddr_q;
         Cp0AddrCount:    cp0_rdata_o = count;
         Cp0AddrCompare:  cp0_rdata_o = compare;
         Cp0AddrStatus:   cp0_rdata_o = status_q;
         Cp0AddrCause:    cp0_rdata_o = cause;
         Cp0AddrEpc:      cp0_rdata_o = epc_q;
         default:         cp0_rdata_o = 32'd0;
      endcase
   end

   // TLB refill gets its own vector only when not already in exception level.
   assign vec_base = status_q[StatusBev] ? VEC_BASE_BEV : VEC_BASE;
   assign vec_off  = ((exc_type_i == ExcTTlbr) && !status_q[StatusExl]) ? 32'h0 : 32'h180;

   assign flush_o      = exc_flag_i;
   assign flush_pc_o   = is_eret ? epc_q : vec_base + vec_off;
   assign cp0_status_o = status_q;
   assign cp0_cause_o  = cause;
   assign cp0_epc_o    = epc_q;

endmodule

// File: tb/tb_exc_entry.sv
// tb_exc_entry: directed self-checking bench for exc_entry.
module tb_exc_entry;
   import exc_entry_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        exc_flag;
   logic [4:0]  exc_type;
   logic [31:0] exc_baddr;
   logic        exc_save;
   logic [31:0] pc;
   logic        in_dslot;
   logic [5:0]  ext_int;
   logic        cp0_we;
   logic [7:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic [31:0] cp0_rdata, cp0_status, cp0_cause, cp0_epc;
   logic        flush;
   logic [31:0] flush_pc;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   exc_entry dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .exc_flag_i   (exc_flag),
      .exc_type_i   (exc_type),
      .exc_baddr_i  (exc_baddr),
      .exc_save_i   (exc_save),
      .pc_i         (pc),
      .in_dslot_i   (in_dslot),
      .ext_int_i    (ext_int),
      .cp0_we_i     (cp0_we),
      .cp0_addr_i   (cp0_addr),
      .cp0_wdata_i  (cp0_wdata),
      .cp0_rdata_o  (cp0_rdata),
      .cp0_status_o (cp0_status),
      .cp0_cause_o  (cp0_cause),
      .cp0_epc_o    (cp0_epc),
      .flush_o      (flush),
      .flush_pc_o   (flush_pc)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [7:0] addr, input logic [31:0] data);
      cp0_we = 1'b1; cp0_addr = addr; cp0_wdata = data;
      tick();
      cp0_we = 1'b0;
   endtask

   task automatic mfc0(input logic [7:0] addr, output logic [31:0] data);
      cp0_addr = addr;
      #1;
      data = cp0_rdata;
   endtask

   // Present an exception/ERET for one cycle; the caller checks flush outputs first.
   task automatic raise(input logic [4:0] t, input logic [31:0] p, input logic ds,
                        input logic sv, input logic [31:0] ba);
      exc_flag = 1'b1; exc_type = t; pc = p; in_dslot = ds; exc_save = sv; exc_baddr = ba;
      #1;
   endtask

   task automatic retire();
      tick();
      exc_flag = 1'b0; exc_type = ExcTNoExc; exc_save = 1'b0; in_dslot = 1'b0;
   endtask

   logic [31:0] rd;

   initial begin
      rst = 1'b1; exc_flag = 1'b0; exc_type = ExcTNoExc; exc_baddr = '0; exc_save = 1'b0;
      pc = '0; in_dslot = 1'b0; ext_int = '0; cp0_we = 1'b0; cp0_addr = '0; cp0_wdata = '0;

      // Reset state
      tick();
      check_eq("rst_status", cp0_status, 32'h0040_0000);
      check_eq("rst_cause", cp0_cause, 32'h0);
      check_eq("rst_epc", cp0_epc, 32'h0);
      check_eq("rst_flush", {31'd0, flush}, 32'h0);
      mfc0(Cp0AddrBadVAddr, rd); check_eq("rst_badvaddr", rd, 32'h0);
      mfc0(Cp0AddrCount, rd);    check_eq("rst_count", rd, 32'h0);
      rst = 1'b0;

      // Count advances every other cycle; Count==Compare==0 sets TI and IP7 at once
      tick(); tick();
      mfc0(Cp0AddrCount, rd); check_eq("count_2cyc", rd, 32'd1);
      check_eq("cause_ti_after_rst", cp0_cause, 32'h4000_8000);
      tick(); tick();
      mfc0(Cp0AddrCount, rd); check_eq("count_4cyc", rd, 32'd2);
      mfc0(8'h78, rd); check_eq("unmapped_read", rd, 32'h0);

      // Status write mask, then BEV=0 EXL=0
      mtc0(Cp0AddrStatus, 32'hFFFF_FFFF);
      check_eq("status_mask", cp0_status, 32'h0040_FF07);
      mtc0(Cp0AddrStatus, 32'h0);
      check_eq("status_clear", cp0_status, 32'h0);

      // Syscall in a delay slot
      raise(ExcTSysC, 32'h8000_1004, 1'b1, 1'b0, 32'h0);
      check_eq("sysc_flush", {31'd0, flush}, 32'h1);
      check_eq("sysc_flush_pc", flush_pc, 32'h8000_0180);
      retire();
      check_eq("sysc_epc", cp0_epc, 32'h8000_1000);
      check_eq("sysc_bd", {31'd0, cp0_cause[31]}, 32'h1);
      check_eq("sysc_exccode", {27'd0, cp0_cause[6:2]}, 32'd8);
      check_eq("sysc_status", cp0_status, 32'h0000_0002);

      // TLB refill store, EXL=0 -> refill vector
      mtc0(Cp0AddrStatus, 32'h0);
      raise(ExcTTlbr, 32'h8000_3000, 1'b0, 1'b1, 32'h0040_0010);
      check_eq("tlbr_flush_pc", flush_pc, 32'h8000_0000);
      retire();
      check_eq("tlbr_exccode", {27'd0, cp0_cause[6:2]}, 32'd3);
      mfc0(Cp0AddrBadVAddr, rd); check_eq("tlbr_badvaddr", rd, 32'h0040_0010);
      check_eq("tlbr_epc", cp0_epc, 32'h8000_3000);
      check_eq("tlbr_bd", {31'd0, cp0_cause[31]}, 32'h0);

      // Nested TLB refill with EXL=1 -> general vector, EPC kept
      raise(ExcTTlbr, 32'h8000_4000, 1'b1, 1'b0, 32'h0000_0020);
      check_eq("tlbr_exl_flush_pc", flush_pc, 32'h8000_0180);
      retire();
      check_eq("tlbr_exl_epc", cp0_epc, 32'h8000_3000);
      check_eq("tlbr_exl_bd", {31'd0, cp0_cause[31]}, 32'h0);
      check_eq("tlbr_exl_exccode", {27'd0, cp0_cause[6:2]}, 32'd2);

      // ERET with a concurrent MTC0 EPC that must be discarded
      mtc0(Cp0AddrEpc, 32'h8000_2000);
      cp0_we = 1'b1; cp0_addr = Cp0AddrEpc; cp0_wdata = 32'h1234_5678;
      raise(ExcTEret, 32'h0, 1'b0, 1'b0, 32'h0);
      check_eq("eret_flush", {31'd0, flush}, 32'h1);
      check_eq("eret_flush_pc", flush_pc, 32'h8000_2000);
      retire();
      cp0_we = 1'b0;
      check_eq("eret_status", cp0_status, 32'h0);
      check_eq("eret_epc_kept", cp0_epc, 32'h8000_2000);

      // Timer: Count=0, then Compare=10; Count reaches 10 twenty edges after the Count write
      mtc0(Cp0AddrCount, 32'h0);
      mtc0(Cp0AddrCompare, 32'd10);
      check_eq("cmp_wr_ti_clr", {31'd0, cp0_cause[30]}, 32'h0);
      repeat (19) tick();
      mfc0(Cp0AddrCount, rd); check_eq("count_ten", rd, 32'd10);
      check_eq("ti_not_yet", {31'd0, cp0_cause[30]}, 32'h0);
      tick();
      check_eq("ti_set", {31'd0, cp0_cause[30]}, 32'h1);
      check_eq("ip7_set", {31'd0, cp0_cause[15]}, 32'h1);
      mtc0(Cp0AddrCompare, 32'd100);
      check_eq("ti_ack", {31'd0, cp0_cause[30]}, 32'h0);
      check_eq("ip7_ack", {31'd0, cp0_cause[15]}, 32'h0);

      // Hardware interrupt line 0 -> Cause.IP2 one cycle later
      ext_int = 6'b000001;
      #1;
      check_eq("ip2_before", {31'd0, cp0_cause[10]}, 32'h0);
      tick();
      check_eq("ip2_after", {31'd0, cp0_cause[10]}, 32'h1);
      ext_int = 6'b0;

      // Address error on load
      raise(ExcTAdE, 32'h8000_5000, 1'b0, 1'b0, 32'h0000_0003);
      check_eq("ade_flush_pc", flush_pc, 32'h8000_0180);
      retire();
      check_eq("ade_exccode", {27'd0, cp0_cause[6:2]}, 32'd4);
      mfc0(Cp0AddrBadVAddr, rd); check_eq("ade_badvaddr", rd, 32'h0000_0003);

      // BEV=1 vector; overflow leaves BadVAddr alone
      mtc0(Cp0AddrStatus, 32'h0040_0000);
      raise(ExcTOv, 32'h8000_6000, 1'b0, 1'b0, 32'hDEAD_BEEF);
      check_eq("bev_flush_pc", flush_pc, 32'hBFC0_0380);
      retire();
      check_eq("ov_exccode", {27'd0, cp0_cause[6:2]}, 32'd12);
      mfc0(Cp0AddrBadVAddr, rd); check_eq("ov_badvaddr", rd, 32'h0000_0003);
      check_eq("ov_epc", cp0_epc, 32'h8000_6000);

      // Asynchronous reset mid-operation
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_rst_status", cp0_status, 32'h0040_0000);
      check_eq("async_rst_epc", cp0_epc, 32'h0);
      check_eq("async_rst_cause", cp0_cause, 32'h0);
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exc_entry.md
# exc_entry

CP0 exception-entry and return unit: consumes the prioritized exception report from the memory-stage exception detector and commits its architectural effects. It owns Status, Cause, EPC, BadVAddr, Count and Compare. It generates the pipeline flush and redirect PC for exception entry and ERET, and feeds the interrupt-pending and mask bits back to the detector. It sits beside the memory/writeback boundary.

## Interface
- `VEC_BASE`, 32'h8000_0000, exception vector base when Status.BEV=0
- `VEC_BASE_BEV`, 32'hBFC0_0200, exception vector base when Status.BEV=1
- `clk`  in  1  core clock
- `rst`  in  1  reset, asynchronous, active-high
- `exc_flag`  in  1  exception or ERET present in memory stage this cycle
- `exc_type`  in  5  ExcT_* code (NoExc, Intr, AdE, TLBR, TLBI, TLBM, IBE, DBE, CpU, RI, Ov, Trap, SysC, Bp, ERET)
- `exc_baddr`  in  32  faulting virtual address (valid for AdE/TLB*)
- `exc_save`  in  1  data-side fault is a store (selects AdES/TLBS vs AdEL/TLBL)
- `pc`  in  32  PC of the memory-stage instruction
- `in_dslot`  in  1  memory-stage instruction is in a branch delay slot
- `ext_int`  in  6  hardware interrupt lines, level-sensitive
- `cp0_we`  in  1  MTC0 write enable
- `cp0_addr`  in  8  {rd[4:0], sel[2:0]}
- `cp0_wdata`  in  32  MTC0 data
- `cp0_rdata`  out  32  MFC0 data, combinational from cp0_addr
- `cp0_Status`, `cp0_Cause`, `cp0_EPC`  out  32 each  current register values
- `flush`  out  1  squash all younger stages this cycle
- `flush_pc`  out  32  fetch redirect target, valid when flush=1

## Operation
- Registers (addr rd/sel 0): BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14; other addresses read 0, writes ignored.
- Entry (exc_flag=1, exc_type not ERET/NoExc), at clock edge:
  - If Status.EXL=0: EPC <= in_dslot ? pc-4 : pc; Cause.BD <= in_dslot.
  - If Status.EXL=1: EPC and BD unchanged.
  - Status.EXL <= 1.
  - Cause.ExcCode <= map: Intr 0, TLBM 1, TLBR/TLBI 2 (3 if exc_save), AdE 4 (5 if exc_save), IBE 6, DBE 7, SysC 8, Bp 9, RI 10, CpU 11, Ov 12, Trap 13.
  - BadVAddr <= exc_baddr only for AdE/TLBR/TLBI/TLBM.
- ERET: Status.EXL <= 0; flush_pc = EPC.
- flush = exc_flag (combinational, same cycle).
- flush_pc (entry) = base + offset:
  - base = BEV ? VEC_BASE_BEV : VEC_BASE.
  - offset 0x000 for TLBR with EXL=0, else 0x180.
- MTC0 writable bits:
  - Status: BEV[22], IM[15:8], ERL[2], EXL[1], IE[0].
  - Cause: IP[9:8].
  - EPC, BadVAddr (no), Count, Compare: full.
  - Unlisted bits read 0.
- Interrupts: Cause.IP[7:2] <= {ext_int[5] | timer_int, ext_int[4:0]} every cycle; Cause.TI = timer_int.
- Timer: 1-bit toggle; Count increments on cycles where toggle=1 (every other cycle), wraps 0xFFFF_FFFF->0. timer_int set when Count==Compare (Compare nonzero-independent), cleared only by MTC0 to Compare.
- Simultaneous events: exception/ERET and cp0_we same cycle -> write discarded. MTC0 Count and increment -> write wins, toggle reset to 0. Compare match and Compare write -> write wins, timer_int cleared.

## Timing
- Reset values: Status 32'h0040_0000 (BEV=1), Cause 0, EPC 0, BadVAddr 0, Count 0, Compare 0, toggle 0, timer_int 0; flush 0 while exc_flag 0.
- Register updates visible one cycle after the triggering edge; cp0_rdata and flush/flush_pc are zero-latency.
- ext_int to Cause.IP: 1 cycle. Count==Compare to Cause.TI: 1 cycle.
- Reset mid-operation clears all state immediately regardless of pending exception.

## Structure
- Shared package/defines: ExcT_* codes, ExcCode values, CP0 register addresses, Status/Cause bit-field positions (IP, IM, IE, EXL, ERL, BEV, BD, TI).
- One sub-module: `cp0_timer` (Count, Compare, toggle, timer_int).

## Test plan
- Reset, release -> Status=0x0040_0000, others 0; Count=1 after 2 cycles, 2 after 4.
- BEV=0, EXL=0, pc=0x8000_1004, in_dslot=1, SysC -> flush=1, flush_pc=0x8000_0180, EPC=0x8000_1000, BD=1, ExcCode=8, EXL=1.
- EXL=0, TLBR, exc_save=1, exc_baddr=0x0040_0010 -> flush_pc=0x8000_0000, ExcCode=3, BadVAddr=0x0040_0010; repeat with EXL=1 -> flush_pc=0x8000_0180, EPC unchanged.
- ERET with EPC=0x8000_2000 -> flush_pc=0x8000_2000, EXL=0; MTC0 in same cycle ignored.
- Compare=10, Count=0 -> TI=1 and IP7=1 one cycle after Count=10; MTC0 Compare -> TI=0.
- ext_int=6'b000001 -> Cause[10]=1 next cycle; AdE, exc_save=0 -> ExcCode=4.
